// File: rtl/camera_dvp_capture.sv
// DVP camera capture: registers the 8-bit sensor bus, packs byte pairs into 16-bit words
// and writes them to the prefetch FIFO, with settling-frame skip and line/frame geometry checks.
module camera_dvp_capture #(
    parameter int SKIP_FRAMES = 10,
    parameter int H_PIX       = 1280,
    parameter int V_LINES     = 720,
    parameter int BYTE_ORDER  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    input  logic        fifo_wr_vld,
    input  logic        err_clr,
    output logic        fifo_wr_en,
    output logic [15:0] fifo_wr_data,
    output logic        frame_start,
    output logic        frame_done,
    output logic [7:0]  frame_cnt,
    output logic        line_err,
    output logic        ovf_err
);
    localparam logic [1:0] S_SKIP   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;

    logic        r_vs, r_vs_d, r_hr, r_hr_d;
    logic [7:0]  r_data, r_first;
    logic [1:0]  r_state;
    logic [15:0] r_skip_cnt;
    logic        r_phase;
    logic [15:0] r_pix_cnt;
    logic [11:0] r_line_cnt;

    logic        w_vs_rise, w_vs_fall, w_hr_fall;
    logic        w_active, w_frame_end, w_line_end, w_pack, w_word_form;
    logic [15:0] w_word, w_skip_next;
    logic [11:0] w_line_next, w_lines_final;
    logic        w_line_err_set, w_ovf_set;

    assign w_vs_rise   = r_vs & ~r_vs_d;
    assign w_vs_fall   = ~r_vs & r_vs_d;
    assign w_hr_fall   = ~r_hr & r_hr_d;
    assign w_active    = (r_state == S_ACTIVE);
    assign w_frame_end = w_active & w_vs_rise;
    // A vsync rise with href still high closes the open line before the frame ends.
    assign w_line_end  = w_active & (w_hr_fall | (w_vs_rise & r_hr));
    assign w_pack      = w_active & r_hr & ~w_vs_rise;
    assign w_word_form = w_pack & r_phase;
    assign w_word      = (BYTE_ORDER != 0) ? {r_data, r_first} : {r_first, r_data};
    assign w_skip_next = r_skip_cnt + 16'd1;
    assign w_line_next = (r_line_cnt == 12'hFFF) ? r_line_cnt : r_line_cnt + 12'd1;
    assign w_lines_final = w_line_end ? w_line_next : r_line_cnt;

    assign w_line_err_set = (w_line_end & (r_phase | (r_pix_cnt != 16'(H_PIX))))
                          | (w_frame_end & (w_lines_final != 12'(V_LINES)));
    assign w_ovf_set      = w_word_form & ~fifo_wr_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs   <= 1'b0;
            r_vs_d <= 1'b0;
            r_hr   <= 1'b0;
            r_hr_d <= 1'b0;
            r_data <= 8'd0;
        end else begin
            r_vs   <= cam_vsync;
            r_vs_d <= r_vs;
            r_hr   <= cam_href;
            r_hr_d <= r_hr;
            r_data <= cam_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_SKIP;
            r_skip_cnt  <= 16'd0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_cnt   <= 8'd0;
        end else begin
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            case (r_state)
                S_SKIP: begin
                    if (r_skip_cnt >= 16'(SKIP_FRAMES)) begin
                        r_state <= S_WAIT;
                    end else if (w_vs_rise) begin
                        r_skip_cnt <= w_skip_next;
                        if (w_skip_next >= 16'(SKIP_FRAMES)) r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_vs_fall) begin
                        r_state     <= S_ACTIVE;
                        frame_start <= 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (w_vs_rise) begin
                        r_state    <= S_WAIT;
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 8'd1;
                    end
                end
                default: r_state <= S_SKIP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase    <= 1'b0;
            r_first    <= 8'd0;
            r_pix_cnt  <= 16'd0;
            r_line_cnt <= 12'd0;
        end else begin
            r_phase <= w_pack ? ~r_phase : 1'b0;
            if (w_pack && !r_phase) r_first <= r_data;
            if ((r_state == S_WAIT) && w_vs_fall) begin
                r_pix_cnt  <= 16'd0;
                r_line_cnt <= 12'd0;
            end else if (w_line_end) begin
                r_pix_cnt  <= 16'd0;
                r_line_cnt <= w_line_next;
            end else if (w_word_form && (r_pix_cnt != 16'hFFFF)) begin
                r_pix_cnt <= r_pix_cnt + 16'd1;
            end
        end
    end

    // A word that finds the FIFO full is dropped outright; the sensor cannot be stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= 16'd0;
            line_err     <= 1'b0;
            ovf_err      <= 1'b0;
        end else begin
            fifo_wr_en <= w_word_form & fifo_wr_vld;
            if (w_word_form) fifo_wr_data <= w_word;
            if (w_line_err_set)  line_err <= 1'b1;
            else if (err_clr)    line_err <= 1'b0;
            if (w_ovf_set)       ovf_err  <= 1'b1;
            else if (err_clr)    ovf_err  <= 1'b0;
        end
    end
endmodule
